// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores through a direct-mapped write-through data cache.
// Define MEM_STAGE_DCACHE_EN to build the cache; otherwise every load goes to backing memory.
module mem_stage #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VALID,
    input  logic [4:0]  CONTROL,
    input  logic        ZERO,
    input  logic [31:0] ALU_RESULT,
    input  logic [31:0] READ_DATA_2,
    output logic        HIT,
    output logic [31:0] MEM_READ_DATA,
    output logic        PC_SRC,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_q, resp_d;

    logic        is_access, is_store, is_load, ack_fire;
    logic        line_hit, fill_en, wr_en;
    logic [31:0] line_data;
    logic        unused_bits;

    assign is_access = VALID && (CONTROL[2] || CONTROL[1]);
    assign is_store  = is_access && CONTROL[1];
    assign is_load   = is_access && !CONTROL[1];
    // An ack only counts while a request is actually outstanding.
    assign ack_fire  = MEM_ACK && mem_req_q;

    assign unused_bits = ^{ALU_RESULT[1:0], CONTROL[4:3]};

`ifdef MEM_STAGE_DCACHE_EN
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign idx       = ALU_RESULT[IDX_W+1:2];
    assign tag       = ALU_RESULT[31:IDX_W+2];
    assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign line_data = data_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= MEM_RDATA;
        end else if (wr_en) begin
            data_q[idx] <= READ_DATA_2;
        end
    end
`else
    logic unused_cache;

    assign line_hit     = 1'b0;
    assign line_data    = '0;
    assign unused_cache = ^{fill_en, wr_en};
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        resp_d        = resp_q;
        HIT           = 1'b0;
        MEM_READ_DATA = '0;
        fill_en       = 1'b0;
        wr_en         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!is_access) begin
                    HIT = 1'b1;
                end else if (is_store) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {ALU_RESULT[31:2], 2'b00};
                    mem_wdata_d = READ_DATA_2;
                end else if (line_hit) begin
                    HIT           = 1'b1;
                    MEM_READ_DATA = line_data;
                end else begin
                    state_d    = FILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {ALU_RESULT[31:2], 2'b00};
                end
            end
            FILL: begin
                if (ack_fire) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    resp_d    = MEM_RDATA;
                    fill_en   = 1'b1;
                end
            end
            WRITE: begin
                if (ack_fire) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wr_en     = line_hit;
                end
            end
            RESP: begin
                HIT           = 1'b1;
                MEM_READ_DATA = is_load ? resp_q : 32'h0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            resp_q      <= resp_d;
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign PC_SRC    = VALID && CONTROL[0] && ZERO && HIT;

endmodule
